// File: rtl/alu_dispatch.sv
// alu_dispatch -- in-order dispatch buffer in front of the ALU reservation station.
//
// Decoded/renamed ALU instructions are queued in a DEPTH-entry FIFO. Every
// cycle all queued operands, and the operands of the instruction being
// accepted, snoop the ROB broadcast bus. A waiting operand whose producer
// tag is broadcast picks up the value and becomes ready. The oldest entry is
// handed to the reservation station whenever rs_full is low.
//
// Optional feature macro: ALU_DISPATCH_BYPASS_EN
//   defined   : an instruction arriving at an empty FIFO with rs_full=0 is
//               presented directly on rs_* at the same edge (1-cycle latency).
//   undefined : every instruction passes through the FIFO (2-cycle latency).
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               synchronous flush, clears queue and the rs_ce strobe
//   in_valid/in_ready   decoder handshake
//   in_target, in_op    destination ROB tag and ALU op
//   in_val1/2, in_tag1/2  operand values and producer tags (all-ones = ready)
//   rob_valid/ready/tag/val  ROB_N-slot broadcast bus, slot i at [i*W +: W]
//   rs_full             reservation station back-pressure
//   rs_ce               one-cycle strobe, an entry is presented
//   rs_target, rs_op, rs_val1/2, rs_tag1/2  presented entry
module alu_dispatch #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int ROB_N  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TAG_W-1:0]        in_target,
  input  logic [OP_W-1:0]         in_op,
  input  logic [DATA_W-1:0]       in_val1,
  input  logic [DATA_W-1:0]       in_val2,
  input  logic [TAG_W-1:0]        in_tag1,
  input  logic [TAG_W-1:0]        in_tag2,
  input  logic [ROB_N-1:0]        rob_valid,
  input  logic [ROB_N-1:0]        rob_ready,
  input  logic [ROB_N*TAG_W-1:0]  rob_tag,
  input  logic [ROB_N*DATA_W-1:0] rob_val,
  input  logic                    rs_full,
  output logic                    rs_ce,
  output logic [TAG_W-1:0]        rs_target,
  output logic [OP_W-1:0]         rs_op,
  output logic [DATA_W-1:0]       rs_val1,
  output logic [DATA_W-1:0]       rs_val2,
  output logic [TAG_W-1:0]        rs_tag1,
  output logic [TAG_W-1:0]        rs_tag2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  typedef struct packed {
    logic [TAG_W-1:0] target;
    logic [OP_W-1:0]  op;
    opnd_t            o1;
    opnd_t            o2;
  } ent_t;

  // Resolve one operand against the broadcast bus. Matching is done on the
  // original tag; later (higher-index) slots overwrite earlier ones, so the
  // highest matching slot wins.
  function automatic opnd_t snoop(input opnd_t o,
                                  input logic [ROB_N-1:0] hit_en,
                                  input logic [ROB_N*TAG_W-1:0] tags,
                                  input logic [ROB_N*DATA_W-1:0] vals);
    opnd_t r;
    r = o;
    for (int i = 0; i < ROB_N; i++) begin
      if (hit_en[i] && (o.tag != TAG_INVALID) && (o.tag == tags[i*TAG_W +: TAG_W])) begin
        r.val = vals[i*DATA_W +: DATA_W];
        r.tag = TAG_INVALID;
      end
    end
    return r;
  endfunction

  ent_t             fifo_q [DEPTH];
  ent_t             snp    [DEPTH];
  ent_t             in_ent;
  ent_t             in_snp;
  ent_t             head;
  logic [ROB_N-1:0] bcast;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             issue;
  logic             bypass;
  logic             push;

  // Stage: snoop (combinational, feeds both storage and issue register)
  assign bcast = rob_valid & rob_ready;

  always_comb begin
    in_ent.target = in_target;
    in_ent.op     = in_op;
    in_ent.o1     = '{tag: in_tag1, val: in_val1};
    in_ent.o2     = '{tag: in_tag2, val: in_val2};
    in_snp        = in_ent;
    in_snp.o1     = snoop(in_ent.o1, bcast, rob_tag, rob_val);
    in_snp.o2     = snoop(in_ent.o2, bcast, rob_tag, rob_val);
    for (int k = 0; k < DEPTH; k++) begin
      snp[k]    = fifo_q[k];
      snp[k].o1 = snoop(fifo_q[k].o1, bcast, rob_tag, rob_val);
      snp[k].o2 = snoop(fifo_q[k].o2, bcast, rob_tag, rob_val);
    end
  end

  assign head = snp[rd_ptr];

  // in_ready deliberately ignores a same-cycle pop: a full FIFO never pushes.
  assign in_ready = rst && !flush && (count < CNT_W'(DEPTH));
  assign issue    = (count != '0) && !rs_full && !flush;
`ifdef ALU_DISPATCH_BYPASS_EN
  assign bypass   = (count == '0) && in_valid && !rs_full && !flush;
`else
  assign bypass   = 1'b0;
`endif
  assign push     = in_valid && in_ready && !bypass;

  // Stage: FIFO storage. Entries keep absorbing broadcasts while queued;
  // slots outside the valid window are don't-care and need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (push && (wr_ptr == PTR_W'(k)))
        fifo_q[k] <= in_snp;
      else
        fifo_q[k] <= snp[k];
    end
  end

  // Stage: issue register and queue control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rs_ce     <= 1'b0;
      rs_target <= TAG_INVALID;
      rs_op     <= '0;
      rs_val1   <= '0;
      rs_val2   <= '0;
      rs_tag1   <= TAG_INVALID;
      rs_tag2   <= TAG_INVALID;
    end else if (flush) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rs_ce     <= 1'b0;
      rs_target <= TAG_INVALID;
    end else begin
      if (issue) begin
        rs_ce     <= 1'b1;
        rs_target <= head.target;
        rs_op     <= head.op;
        rs_val1   <= head.o1.val;
        rs_val2   <= head.o2.val;
        rs_tag1   <= head.o1.tag;
        rs_tag2   <= head.o2.tag;
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end else if (bypass) begin
        rs_ce     <= 1'b1;
        rs_target <= in_snp.target;
        rs_op     <= in_snp.op;
        rs_val1   <= in_snp.o1.val;
        rs_val2   <= in_snp.o2.val;
        rs_tag1   <= in_snp.o1.tag;
        rs_tag2   <= in_snp.o2.tag;
      end else begin
        rs_ce     <= 1'b0;
        rs_target <= TAG_INVALID;
      end
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(issue);
    end
  end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- In-order dispatch buffer that drives the producer side of the ALU reservation-station interface: ce, target, val[1:2], tag[1:2] and op.
- Accepts decoded and renamed ALU instructions from the decoder. Each carries a destination ROB tag, two operand value/tag pairs and an ALU op.
- Buffers them in a small FIFO and snoops the ROB broadcast so that waiting operands resolve before hand-off.
- Sends the oldest entry to the reservation station whenever the station's full flag is low.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_W, 5, ROB tag width; all-ones is TAG_INVALID.
- DATA_W, 32, operand width.
- OP_W, 4, ALU op width.
- ROB_N, 8, number of ROB broadcast slots snooped.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  decoder offers an instruction.
- in_ready  out  1  dispatch can accept an instruction.
- in_target  in  TAG_W  destination ROB tag.
- in_op  in  OP_W  ALU op code.
- in_val1, in_val2  in  DATA_W  operand values; meaningful when the matching tag is TAG_INVALID.
- in_tag1, in_tag2  in  TAG_W  producer tags; TAG_INVALID means the operand is ready.
- rob_valid, rob_ready  in  ROB_N  per-slot broadcast flags.
- rob_tag  in  ROB_N*TAG_W  per-slot tags, slot i at bits [i*TAG_W +: TAG_W].
- rob_val  in  ROB_N*DATA_W  per-slot results.
- rs_full  in  1  reservation station cannot accept an entry.
- rs_ce  out  1  one-cycle strobe; an entry is presented this cycle.
- rs_target  out  TAG_W  entry target; TAG_INVALID when rs_ce=0.
- rs_op  out  OP_W  entry op.
- rs_val1, rs_val2  out  DATA_W  operand values.
- rs_tag1, rs_tag2  out  TAG_W  unresolved producer tags.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, read and write pointers=0.
  - rs_ce=0, rs_target=TAG_INVALID, rs_tag1/rs_tag2=TAG_INVALID, rs_op=0, rs_val1/rs_val2=0.
  - in_ready=0 while rst=0.
- in_ready = rst && !flush && (count<DEPTH). It is independent of rs_full and of any same-cycle pop, so when the FIFO is full nothing is pushed even if a pop happens that cycle.
- Push: a posedge with in_valid && in_ready writes the entry at the write pointer. The write pointer wraps modulo DEPTH.
- Snoop:
  - Every posedge, each valid FIFO entry and the entry being pushed are checked against every slot i with rob_valid[i] && rob_ready[i].
  - An operand whose tag is not TAG_INVALID and equals rob_tag[i] captures rob_val[i]; its tag becomes TAG_INVALID.
  - If several slots match, the highest index wins.
- Issue:
  - A posedge with count>0 && !rs_full && !flush presents the head entry.
  - The head's operands as updated by that same cycle's snoop are presented: rs_ce<=1 and all rs_* outputs <= head fields.
  - The head is popped and the read pointer wraps modulo DEPTH.
  - Otherwise rs_ce<=0 and rs_target<=TAG_INVALID; the other rs_* outputs hold.
- Latency: an instruction pushed at edge N into an empty FIFO appears on rs_* after edge N+1 when rs_full=0.
- Ordering: strictly in order; no entry overtakes the head.
- Pointer rule: push and pop in the same cycle leave count unchanged and both pointers advance.
- Flush: at a posedge with flush=1, count, pointers, rs_ce and rs_target are cleared as on reset. Flush has priority over push and issue.
- rs_full is sampled only at posedge. While rs_full=1 the FIFO fills up to DEPTH, then in_ready drops.
- Reset mid-operation discards all entries; no partial entry survives.

Optional Feature:
- Macro: ALU_DISPATCH_BYPASS_EN.
- Defined:
  - If count==0, in_valid, !rs_full and !flush at a posedge, the incoming instruction, snooped that same cycle, drives rs_* directly.
  - rs_ce=1 and the FIFO is not written.
  - Latency drops to 1 cycle.
- Undefined: every instruction passes through the FIFO and latency is 2 cycles.

Test Plan:
- Reset, then push op=ADD, target=3, val1=5, val2=7, tags TAG_INVALID, with rs_full=0 -> one cycle later rs_ce=1, rs_target=3, rs_val1=5, rs_val2=7; next cycle rs_ce=0, rs_target=5'h1F.
- Push target=2 with tag1=6; at the next posedge broadcast slot 4 with valid=1, ready=1, tag=6, val=0x1234 -> issued entry has rs_val1=0x1234 and rs_tag1=TAG_INVALID.
- Hold rs_full=1 and push 5 instructions -> in_ready falls after the 4th. Release rs_full -> targets issue in push order on 4 consecutive cycles.
- Fill the FIFO, then pulse flush=1 for one cycle -> count=0, rs_ce stays 0 and no stale target is issued; in_ready returns to 1 the following cycle.
- Assert rst=0 asynchronously between edges while 3 entries are queued -> rs_target=TAG_INVALID immediately; after release no entry issues.
- With ALU_DISPATCH_BYPASS_EN, FIFO empty and rs_full=0: push target=9 -> rs_ce=1 and rs_target=9 after the same posedge. Without the macro, this happens one cycle later.
